// File: rtl/axil_warb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_warb_pkg
// Purpose  : Shared types and constants for the AXI4-Lite write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axil_warb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    function automatic bit num_req_legal(input int n);
        return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_warb_pick.sv
`default_nettype none
// ============================================================================
// Module   : axil_warb_pick
// Purpose  : Combinational one-hot winner select. AXIL_WARB_RR_EN selects a
//            round-robin search from i_ptr; otherwise lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module axil_warb_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;

`ifdef AXIL_WARB_RR_EN
    // First pass covers indices at or above the pointer, second pass wraps.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/axil_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axil_write_arbiter
// Purpose  : Shares one AXI4-Lite write channel between NUM_REQ masters; the
//            grant is held until B completes. AXIL_WARB_RR_EN = round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module axil_write_arbiter
    import axil_warb_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 18,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                                      M_AXI_ACLK,
    input  logic                                      M_AXI_ARESETN,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [NUM_REQ-1:0]                        S_AXI_AWVALID,
    output logic [NUM_REQ-1:0]                        S_AXI_AWREADY,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [NUM_REQ*(C_M_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic [NUM_REQ-1:0]                        S_AXI_WVALID,
    output logic [NUM_REQ-1:0]                        S_AXI_WREADY,
    output logic [NUM_REQ*2-1:0]                      S_AXI_BRESP,
    output logic [NUM_REQ-1:0]                        S_AXI_BVALID,
    input  logic [NUM_REQ-1:0]                        S_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             M_AXI_AWADDR,
    output logic                                      M_AXI_AWVALID,
    input  logic                                      M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]             M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]           M_AXI_WSTRB,
    output logic                                      M_AXI_WVALID,
    input  logic                                      M_AXI_WREADY,
    input  logic [1:0]                                M_AXI_BRESP,
    input  logic                                      M_AXI_BVALID,
    output logic                                      M_AXI_BREADY,
    output logic [NUM_REQ-1:0]                        Grant,
    output logic                                      Busy
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (!num_req_legal(NUM_REQ)) begin : g_num_req_check
            $error("axil_write_arbiter: NUM_REQ must be within 2..8");
        end
    endgenerate

    state_t             r_state,   w_state_nx;
    logic [NUM_REQ-1:0] r_grant,   w_grant_nx;
    logic               r_aw_done, w_aw_done_nx;
    logic               r_w_done,  w_w_done_nx;

    logic [NUM_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_pick_ptr;
    logic               w_in_ad, w_in_resp;
    logic               w_req_awvalid, w_req_wvalid, w_req_bready;
    logic               w_aw_hs, w_w_hs, w_b_hs;

    assign w_in_ad   = (r_state == S_ADDR_DATA);
    assign w_in_resp = (r_state == S_RESP);
    assign Grant     = r_grant;
    assign Busy      = w_in_ad | w_in_resp;

    axil_warb_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (S_AXI_AWVALID),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick)
    );

    // Grant is one-hot or zero, so an unprioritised select is sufficient.
    always_comb begin
        M_AXI_AWADDR  = '0;
        M_AXI_WDATA   = '0;
        M_AXI_WSTRB   = '0;
        w_req_awvalid = 1'b0;
        w_req_wvalid  = 1'b0;
        w_req_bready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                M_AXI_AWADDR  = S_AXI_AWADDR[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                M_AXI_WDATA   = S_AXI_WDATA[i*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
                M_AXI_WSTRB   = S_AXI_WSTRB[i*STRB_W +: STRB_W];
                w_req_awvalid = S_AXI_AWVALID[i];
                w_req_wvalid  = S_AXI_WVALID[i];
                w_req_bready  = S_AXI_BREADY[i];
            end
        end
    end

    assign M_AXI_AWVALID = w_in_ad & w_req_awvalid & ~r_aw_done;
    assign M_AXI_WVALID  = w_in_ad & w_req_wvalid & ~r_w_done;
    assign M_AXI_BREADY  = w_in_resp & w_req_bready;

    assign w_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
    assign w_b_hs  = M_AXI_BVALID & M_AXI_BREADY;

    always_comb begin
        S_AXI_AWREADY = '0;
        S_AXI_WREADY  = '0;
        S_AXI_BVALID  = '0;
        S_AXI_BRESP   = {NUM_REQ{RESP_OKAY}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                S_AXI_AWREADY[i] = w_in_ad & M_AXI_AWREADY & ~r_aw_done;
                S_AXI_WREADY[i]  = w_in_ad & M_AXI_WREADY & ~r_w_done;
                S_AXI_BVALID[i]  = w_in_resp & M_AXI_BVALID;
                if (w_in_resp) begin
                    S_AXI_BRESP[2*i +: 2] = M_AXI_BRESP;
                end
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_aw_done_nx = r_aw_done;
        w_w_done_nx  = r_w_done;
        case (r_state)
            S_IDLE: begin
                if (|S_AXI_AWVALID) begin
                    w_grant_nx   = w_pick;
                    w_aw_done_nx = 1'b0;
                    w_w_done_nx  = 1'b0;
                    w_state_nx   = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                w_aw_done_nx = r_aw_done | w_aw_hs;
                w_w_done_nx  = r_w_done | w_w_hs;
                if (w_aw_done_nx && w_w_done_nx) begin
                    w_state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (w_b_hs) begin
                    w_grant_nx = '0;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_grant_nx = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_aw_done <= w_aw_done_nx;
            r_w_done  <= w_w_done_nx;
        end
    end

`ifdef AXIL_WARB_RR_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gidx;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
    end

    // Pointer moves past the requester that just finished its response.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_ptr <= '0;
        end else if (w_in_resp && w_b_hs) begin
            r_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_gidx + PTR_W'(1));
        end
    end

    assign w_pick_ptr = r_ptr;
`else
    assign w_pick_ptr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_write_arbiter
// Purpose  : Directed and randomized self-checking bench for the write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N*AW-1:0] S_AXI_AWADDR;
    logic [N-1:0]    S_AXI_AWVALID;
    logic [N-1:0]    S_AXI_AWREADY;
    logic [N*DW-1:0] S_AXI_WDATA;
    logic [N*SW-1:0] S_AXI_WSTRB;
    logic [N-1:0]    S_AXI_WVALID;
    logic [N-1:0]    S_AXI_WREADY;
    logic [N*2-1:0]  S_AXI_BRESP;
    logic [N-1:0]    S_AXI_BVALID;
    logic [N-1:0]    S_AXI_BREADY;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [SW-1:0]   M_AXI_WSTRB;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;
    logic [N-1:0]    Grant;
    logic            Busy;

    axil_write_arbiter #(
        .NUM_REQ            (N),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .Grant         (Grant),
        .Busy          (Busy)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int m_ptr     = 0;
    bit use_fixed0 = 1'b0;
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    logic [SW-1:0] m_strb [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_ptr();
`ifdef AXIL_WARB_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    // Reference arbitration: first requester found scanning upward from p.
    function automatic int model_pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic drive_req(input logic [N-1:0] mask, input bit fresh);
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (fresh || !S_AXI_AWVALID[i])) begin
                m_addr[i] = AW'($urandom);
                m_data[i] = $urandom;
                m_strb[i] = SW'($urandom);
                if (i == 0 && use_fixed0) begin
                    m_addr[i] = AW'(32'h00010);
                    m_data[i] = 32'hDEADBEEF;
                    m_strb[i] = 4'hF;
                end
            end
            S_AXI_AWADDR[i*AW +: AW] = m_addr[i];
            S_AXI_WDATA[i*DW +: DW]  = m_data[i];
            S_AXI_WSTRB[i*SW +: SW]  = m_strb[i];
            S_AXI_AWVALID[i]         = mask[i];
            S_AXI_WVALID[i]          = mask[i];
        end
    endtask

    task automatic slave_quiet();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        S_AXI_BREADY  = '0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_grant"},    Grant, 0);
        chk({pfx, "_busy"},     Busy, 0);
        chk({pfx, "_m_awvalid"}, M_AXI_AWVALID, 0);
        chk({pfx, "_m_wvalid"}, M_AXI_WVALID, 0);
        chk({pfx, "_m_bready"}, M_AXI_BREADY, 0);
        chk({pfx, "_s_awready"}, S_AXI_AWREADY, 0);
        chk({pfx, "_s_wready"}, S_AXI_WREADY, 0);
        chk({pfx, "_s_bvalid"}, S_AXI_BVALID, 0);
        chk({pfx, "_awaddr"},   M_AXI_AWADDR, 0);
        chk({pfx, "_wdata"},    M_AXI_WDATA, 0);
        chk({pfx, "_wstrb"},    M_AXI_WSTRB, 0);
    endtask

    task automatic do_txn(input logic [N-1:0] mask_idle, input logic [N-1:0] mask_late,
                          input int aw_d, input int w_d, input int b_d, input int br_d,
                          input logic [1:0] bresp, input bit rst_in_resp);
        int           g;
        int           c;
        bit           aw_done, w_done, b_done, awr, wr, bv, br;
        logic [N-1:0] onehot;

        slave_quiet();
        drive_req(mask_idle, 1'b1);
        #1;
        chk("idle_grant", Grant, 0);
        chk("idle_busy", Busy, 0);
        chk("idle_m_awvalid", M_AXI_AWVALID, 0);
        chk("idle_s_awready", S_AXI_AWREADY, 0);
        g = model_pick(mask_idle, cur_ptr());
        onehot = '0;
        onehot[g] = 1'b1;
        tick();

        drive_req(mask_idle | mask_late, 1'b0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        c = 0;
        while (!(aw_done && w_done)) begin
            awr = (c >= aw_d);
            wr  = (c >= w_d);
            M_AXI_AWREADY = awr;
            M_AXI_WREADY  = wr;
            M_AXI_BRESP   = 2'($urandom);
            #1;
            chk("ad_grant", Grant, onehot);
            chk("ad_busy", Busy, 1);
            chk("ad_m_awvalid", M_AXI_AWVALID, !aw_done);
            chk("ad_m_wvalid", M_AXI_WVALID, !w_done);
            chk("ad_awaddr", M_AXI_AWADDR, m_addr[g]);
            chk("ad_wdata", M_AXI_WDATA, m_data[g]);
            chk("ad_wstrb", M_AXI_WSTRB, m_strb[g]);
            chk("ad_s_awready", S_AXI_AWREADY, (awr && !aw_done) ? onehot : '0);
            chk("ad_s_wready", S_AXI_WREADY, (wr && !w_done) ? onehot : '0);
            chk("ad_m_bready", M_AXI_BREADY, 0);
            chk("ad_s_bvalid", S_AXI_BVALID, 0);
            aw_done = aw_done | awr;
            w_done  = w_done | wr;
            tick();
            c++;
        end

        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        c = 0;
        b_done = 1'b0;
        while (!b_done) begin
            bv = (c >= b_d);
            br = (c >= br_d);
            M_AXI_BVALID = bv;
            M_AXI_BRESP  = bresp;
            S_AXI_BREADY = br ? onehot : '0;
            #1;
            if (rst_in_resp && c == 1) begin
                rstn = 1'b0;
                drive_req('0, 1'b0);
                slave_quiet();
                tick();
                chk_reset_outputs("rst_resp");
                rstn  = 1'b1;
                m_ptr = 0;
                return;
            end
            chk("resp_grant", Grant, onehot);
            chk("resp_busy", Busy, 1);
            chk("resp_m_awvalid", M_AXI_AWVALID, 0);
            chk("resp_m_wvalid", M_AXI_WVALID, 0);
            chk("resp_m_bready", M_AXI_BREADY, br);
            chk("resp_s_bvalid", S_AXI_BVALID, bv ? onehot : '0);
            if (bv) begin
                chk("resp_s_bresp", S_AXI_BRESP, 64'(bresp) << (2 * g));
            end
            b_done = bv && br;
            tick();
            c++;
        end
        m_ptr = (g + 1) % N;
        slave_quiet();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
            m_strb[i] = '0;
        end
        rstn = 1'b0;
        slave_quiet();
        drive_req('1, 1'b1);
        tick();
        tick();
        chk_reset_outputs("reset");
        drive_req('0, 1'b0);
        rstn = 1'b1;
        tick();

        // Single transfer with fixed payload on requester 0.
        use_fixed0 = 1'b1;
        do_txn(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
        use_fixed0 = 1'b0;

        // Both requesters hold their requests for four transfers.
        for (int t = 0; t < 4; t++) begin
            do_txn(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
        end

        // AW accepted first, W late; then W first, AW late.
        do_txn(2'b01, 2'b00, 0, 3, 0, 0, 2'b00, 1'b0);
        do_txn(2'b10, 2'b00, 2, 0, 1, 0, 2'b00, 1'b0);

        // Requester 1 backpressures B while requester 0 starts requesting.
        do_txn(2'b10, 2'b01, 0, 0, 0, 2, 2'b00, 1'b0);
        do_txn(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);

        // Slave error returned unchanged.
        do_txn(2'b01, 2'b00, 0, 0, 1, 0, 2'b10, 1'b0);

        for (int t = 0; t < 10; t++) begin
            logic [N-1:0] mi, ml;
            mi = N'($urandom_range(1, (1 << N) - 1));
            ml = N'($urandom);
            do_txn(mi, ml, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 1'b0);
        end

        // Reset in the response phase, then confirm arbitration restarts at 0.
        do_txn(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
        do_txn(2'b10, 2'b00, 0, 0, 5, 0, 2'b00, 1'b1);
        do_txn(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);

        drive_req('0, 1'b0);
        #1;
        chk("final_grant", Grant, 0);
        chk("final_busy", Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_write_arbiter.md
# axil_write_arbiter

Shares one AXI4-Lite write channel into the embedded-memory slave between NUM_REQ AXI4-Lite write masters, such as the UART loader and a host/debug writer. It grants one requester at a time and forwards its AW/W channels to the slave. The grant is held until the slave's B response has been returned to that requester. Read channels are not handled and pass around this block.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2–8.
- C_M_AXI_ADDR_WIDTH, 18: write address width.
- C_M_AXI_DATA_WIDTH, 32: write data width; strobe width is C_M_AXI_DATA_WIDTH/8.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - M_AXI_ACLK  in  1  clock.
  - M_AXI_ARESETN  in  1  synchronous active-low reset.
- Requester side: requester i occupies slice i of each bus.
  - S_AXI_AWADDR  in  NUM_REQ*ADDR  write addresses.
  - S_AXI_AWVALID  in  NUM_REQ  address valid; this is the request line.
  - S_AXI_AWREADY  out  NUM_REQ  address ready.
  - S_AXI_WDATA  in  NUM_REQ*DATA  write data.
  - S_AXI_WSTRB  in  NUM_REQ*DATA/8  write strobes.
  - S_AXI_WVALID  in  NUM_REQ  data valid.
  - S_AXI_WREADY  out  NUM_REQ  data ready.
  - S_AXI_BRESP  out  NUM_REQ*2  write response.
  - S_AXI_BVALID  out  NUM_REQ  response valid.
  - S_AXI_BREADY  in  NUM_REQ  response ready.
- Slave side:
  - M_AXI_AWADDR  out  ADDR  forwarded address.
  - M_AXI_AWVALID  out  1  forwarded address valid.
  - M_AXI_AWREADY  in  1  slave address ready.
  - M_AXI_WDATA  out  DATA  forwarded data.
  - M_AXI_WSTRB  out  DATA/8  forwarded strobes.
  - M_AXI_WVALID  out  1  forwarded data valid.
  - M_AXI_WREADY  in  1  slave data ready.
  - M_AXI_BRESP  in  2  slave response.
  - M_AXI_BVALID  in  1  slave response valid.
  - M_AXI_BREADY  out  1  response ready toward slave.
- Status:
  - Grant  out  NUM_REQ  one-hot registered grant; zero when idle.
  - Busy  out  1  high in S_ADDR_DATA and S_RESP.

## Operation
- States:
  - S_IDLE: no grant; all READY/VALID outputs are 0. If any S_AXI_AWVALID bit is set, register the winner into Grant, clear aw_done/w_done, and go to S_ADDR_DATA.
  - S_ADDR_DATA: the granted requester's AW and W channels pass through combinationally.
    - M_AXI_AWVALID = S_AXI_AWVALID[g] & !aw_done; M_AXI_WVALID = S_AXI_WVALID[g] & !w_done.
    - S_AXI_AWREADY[g] = M_AXI_AWREADY & !aw_done; S_AXI_WREADY[g] is derived the same way from M_AXI_WREADY and w_done.
    - The aw_done and w_done flags set on their respective handshakes. When both are set (or set in the same cycle), go to S_RESP.
  - S_RESP: M_AXI_BREADY = S_AXI_BREADY[g]; S_AXI_BVALID[g] = M_AXI_BVALID; BRESP is forwarded unchanged, including SLVERR (2'b10). On the B handshake, update the priority pointer, clear Grant, and go to S_IDLE.
- Non-granted requesters see READY = 0, BVALID = 0 and BRESP = 2'b00 at all times.
- AW and W may complete in either order or in the same cycle. The channel already accepted has its VALID forced low toward the slave.
- Requester deasserting AWVALID before its handshake is a protocol violation. It is unsupported; the grant is held regardless.
- Reset values: state S_IDLE, Grant 0, Busy 0, aw_done/w_done 0, priority pointer 0. All VALID/READY outputs are 0; the AWADDR, WDATA and WSTRB outputs are 0.

## Timing
- Arbitration latency is 1 cycle: a request sampled in S_IDLE at edge n is visible on the M_AXI side in cycle n+1.
- Minimum transaction is 3 cycles (IDLE, ADDR_DATA, RESP); back-to-back grants always include one S_IDLE cycle.
- Backpressure from the slave on AW, W or B holds the state and Grant indefinitely. No timeout.
- Reset mid-transaction returns to S_IDLE on the next edge with all outputs at reset values. The slave is reset on the same signal.

## Configuration
- AXIL_WARB_RR_EN defined: round-robin arbitration. Search starts at pointer p; after completing requester g, p = (g+1) mod NUM_REQ.
- AXIL_WARB_RR_EN undefined: fixed priority, lowest index wins, and the pointer logic is removed.

## Structure
- Package axil_warb_pkg holds:
  - the state enum (S_IDLE, S_ADDR_DATA, S_RESP);
  - the RESP_OKAY, RESP_SLVERR and RESP_DECERR constants;
  - the NUM_REQ range check.
- Sub-module axil_warb_pick takes the request vector and pointer and returns a one-hot winner. It is purely combinational, and the macro selects its round-robin or fixed-priority body.

## Test plan
- Single transfer: req0 AWADDR=0x00010, WDATA=0xDEADBEEF, WSTRB=4'hF, slave ready at once, BRESP=OKAY.
  - Cycle 1: M_AXI shows the address and data.
  - Cycle 2: S_AXI_BVALID[0]=1.
  - Grant[1], S_AXI_AWREADY[1], S_AXI_WREADY[1] and S_AXI_BVALID[1] stay 0 throughout.
- Both requesters hold AWVALID continuously for 4 transfers: with RR_EN, grants are 0,1,0,1; without it, grants are 0,0,0,0.
- Out-of-order accept: AWREADY in cycle 1, WREADY delayed to cycle 4.
  - M_AXI_AWVALID drops in cycle 2; WDATA is held stable.
  - S_RESP is entered after cycle 4.
- Response backpressure: requester 1 holds BREADY low for 2 cycles while BVALID=1.
  - M_AXI_BREADY stays 0 and Grant stays 2'b10.
  - Req0, asserting meanwhile, is not granted until after the handshake.
- Error pass-through: slave returns BRESP=2'b10, and requester 0 receives 2'b10.
- Reset asserted during S_RESP: next cycle all VALID/READY outputs are 0, Grant=0, Busy=0, and the pointer is 0.
